// File: rtl/dma_cmd_queue.sv
// ---------------------------------------------------------------------------
// dma_cmd_queue
//
// Descriptor queue and issuer placed in front of the ROM-to-RAM DMA engine.
// Copy descriptors (src, dst, len) are buffered in a small FIFO and launched
// one at a time on the DMA's start/src/dest/amount inputs. The block waits for
// the DMA's done, then returns one completion record per descriptor, in order.
//
// Optional feature (compile-time macro):
//   DMA_CMDQ_TIMEOUT_EN - adds a WAIT-state watchdog. After TIMEOUT_CYCLES
//                         WAIT cycles without dma_done the descriptor is
//                         retired with status 2'b10. Without the macro no
//                         counter is built and WAIT only exits on dma_done.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-low reset
//   cmd_valid    descriptor offered
//   cmd_ready    queue can accept (count < QUEUE_DEPTH; no bypass when full)
//   cmd_src      source (ROM) address
//   cmd_dst      destination (RAM) address
//   cmd_len      element count
//   dma_start    one-cycle launch pulse to the DMA
//   dma_src      descriptor source address held for the DMA
//   dma_dst      descriptor destination address held for the DMA
//   dma_len      descriptor element count held for the DMA
//   dma_done     DMA completion (level or pulse), sampled only in WAIT
//   cpl_valid    completion record available
//   cpl_ready    consumer accepts the completion record
//   cpl_status   00 ok, 01 zero-length skipped, 10 timeout
//   cpl_seq      completion sequence number, wraps 255 -> 0
//   queue_count  descriptors held in the FIFO
//   busy         FSM not idle or FIFO not empty
//   state_dbg    current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 REPORT)
//
// Handshakes: both cmd_* and cpl_* use strict valid/ready. A transfer happens
// on a rising edge where valid and ready are both high. The producer must hold
// valid and its payload stable until that edge; ready never depends on valid,
// so there is no combinational path from valid back to ready.
// ---------------------------------------------------------------------------
module dma_cmd_queue #(
    parameter int ADDR_WIDTH     = 8,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [ADDR_WIDTH-1:0]          cmd_src,
    input  logic [ADDR_WIDTH-1:0]          cmd_dst,
    input  logic [ADDR_WIDTH-1:0]          cmd_len,
    output logic                           dma_start,
    output logic [ADDR_WIDTH-1:0]          dma_src,
    output logic [ADDR_WIDTH-1:0]          dma_dst,
    output logic [ADDR_WIDTH-1:0]          dma_len,
    input  logic                           dma_done,
    output logic                           cpl_valid,
    input  logic                           cpl_ready,
    output logic [1:0]                     cpl_status,
    output logic [7:0]                     cpl_seq,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           busy,
    output logic [1:0]                     state_dbg
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    localparam logic [1:0] STATUS_OK   = 2'b00;
    localparam logic [1:0] STATUS_SKIP = 2'b01;
`ifdef DMA_CMDQ_TIMEOUT_EN
    localparam logic [1:0] STATUS_TMO  = 2'b10;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t state_q, state_d;

    // -----------------------------------------------------------------------
    // Descriptor FIFO
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] src_mem [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] dst_mem [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] len_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] head_src;
    logic [ADDR_WIDTH-1:0] head_dst;
    logic [ADDR_WIDTH-1:0] head_len;

    // Full queue refuses even while a pop is happening on the same edge.
    assign cmd_ready = (count_q < DEPTH_C);
    assign push      = cmd_valid && cmd_ready;

    assign head_src  = src_mem[rd_ptr_q];
    assign head_dst  = dst_mem[rd_ptr_q];
    assign head_len  = len_mem[rd_ptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                src_mem[i] <= '0;
                dst_mem[i] <= '0;
                len_mem[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else if (push) begin
            src_mem[wr_ptr_q] <= cmd_src;
            dst_mem[wr_ptr_q] <= cmd_dst;
            len_mem[wr_ptr_q] <= cmd_len;
            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
        end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Optional WAIT watchdog
    // -----------------------------------------------------------------------
`ifdef DMA_CMDQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_hit;

    // The counter holds the number of completed WAIT cycles; the edge that
    // would bring it to TIMEOUT_CYCLES is the one that leaves WAIT.
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Issue FSM
    // -----------------------------------------------------------------------
    logic       set_status;
    logic [1:0] status_nxt;
    logic       cpl_hs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        set_status = 1'b0;
        status_nxt = STATUS_OK;
        cpl_hs     = 1'b0;
        dma_start  = 1'b0;
        cpl_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    // A zero-length copy is retired without touching the DMA.
                    if (head_len == '0) begin
                        state_d    = S_REPORT;
                        set_status = 1'b1;
                        status_nxt = STATUS_SKIP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                dma_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // done has priority over a watchdog expiry on the same edge.
                if (dma_done) begin
                    state_d    = S_REPORT;
                    set_status = 1'b1;
                    status_nxt = STATUS_OK;
                end
`ifdef DMA_CMDQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d    = S_REPORT;
                    set_status = 1'b1;
                    status_nxt = STATUS_TMO;
                end
`endif
            end
            S_REPORT: begin
                cpl_valid = 1'b1;
                if (cpl_ready) begin
                    cpl_hs  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // DMA descriptor registers: load only on pop, held through the command.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_src <= '0;
            dma_dst <= '0;
            dma_len <= '0;
        end else if (pop) begin
            dma_src <= head_src;
            dma_dst <= head_dst;
            dma_len <= head_len;
        end
    end

    // -----------------------------------------------------------------------
    // Completion record
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpl_status <= STATUS_OK;
        end else if (set_status) begin
            cpl_status <= status_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpl_seq <= 8'd0;
        end else if (cpl_hs) begin
            cpl_seq <= cpl_seq + 8'd1;
        end
    end

    assign queue_count = count_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0);
    assign state_dbg   = state_q;

endmodule
